gpio_cfg_serializer: RTL and testbench

Hardware loader for the GPIO pad-configuration serial chains. Replaces firmware or SPI bit-banging of the housekeeping serial-config register. It sits in housekeeping and shifts one CFG_WIDTH-bit configuration word per GPIO into two parallel chains (data1/data2), then pulses load. It is parametrised in pad count, word width and serial clock rate, and keeps an optional bit-bang bypass.

---
 rtl/gpio_cfg_pkg.sv | 26 ++
 rtl/gpio_cfg_tick.sv | 34 +++
 rtl/gpio_cfg_serializer.sv | 180 ++++++++++++++++++
 tb/tb_gpio_cfg_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and defaults for the GPIO pad-configuration chain loader.
// Holds the loader state encoding and the index-width helper.
package gpio_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      LOAD     = 3'd4,
      DONE     = 3'd5
   } gpio_cfg_state_e;

   localparam int GPIO_CFG_WIDTH = 13;
   localparam int GPIO_NUM_IO    = 19;

   // Width of a counter/index covering 0..n-1, never narrower than one bit.
   function automatic int gpio_idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/gpio_cfg_tick.sv
// Serial half-period timer: counts CLK_DIV cycles after each restart and
// raises expire on the last one, holding there until the next restart.
module gpio_cfg_tick
   import gpio_cfg_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic expire
);

   localparam int TICK_W = gpio_idx_width(CLK_DIV);
   localparam logic [TICK_W-1:0] LAST = TICK_W'(CLK_DIV - 1);

   logic [TICK_W-1:0] cnt_r;

   assign expire = (cnt_r == LAST);

   // Cycle counter within the current state; saturates at LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {TICK_W{1'b0}};
      end else if (restart) begin
         cnt_r <= {TICK_W{1'b0}};
      end else if (!expire) begin
         cnt_r <= cnt_r + TICK_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/gpio_cfg_serializer.sv
// Shifts NUM_IO configuration words (highest index first, MSB first) into two
// lockstep pad chains, then pulses load. Optional bypass: GPIO_CFG_BITBANG_EN.
module gpio_cfg_serializer
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_IO    = GPIO_NUM_IO,
   parameter int CFG_WIDTH = GPIO_CFG_WIDTH,
   parameter int CLK_DIV   = 4,
   localparam int IDX_W    = gpio_idx_width(NUM_IO)
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rstn_i,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [IDX_W-1:0]     cfg_idx_o,
   input  logic [CFG_WIDTH-1:0] cfg_data1_i,
   input  logic [CFG_WIDTH-1:0] cfg_data2_i,
   input  logic                 bitbang_en_i,
   input  logic                 bb_clock_i,
   input  logic                 bb_load_i,
   input  logic                 bb_resetn_i,
   input  logic                 bb_data1_i,
   input  logic                 bb_data2_i,
   output logic                 serial_clock_o,
   output logic                 serial_load_o,
   output logic                 serial_resetn_o,
   output logic                 serial_data1_o,
   output logic                 serial_data2_o
);

   localparam int BIT_W = gpio_idx_width(CFG_WIDTH);

   gpio_cfg_state_e      state_r, state_s, fsm_next_s;
   logic [IDX_W-1:0]     k_r, k_s;
   logic [BIT_W-1:0]     bit_r, bit_s;
   logic [CFG_WIDTH-1:0] sh1_r, sh1_s, sh2_r, sh2_s;
   logic                 tick_s, restart_s, abort_s;
   logic                 busy_r, done_r, clk_r, load_r, resetn_r, d1_r, d2_r;
   logic [IDX_W-1:0]     idx_r;

`ifdef GPIO_CFG_BITBANG_EN
   assign abort_s = bitbang_en_i;
`else
   logic unused_bb_s;
   assign abort_s     = 1'b0;
   assign unused_bb_s = ^{bitbang_en_i, bb_clock_i, bb_load_i, bb_resetn_i, bb_data1_i, bb_data2_i};
`endif

   assign restart_s = (state_s != state_r);

   gpio_cfg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk     (wb_clk_i),
      .rst_n   (wb_rstn_i),
      .restart (restart_s),
      .expire  (tick_s)
   );

   // Next-state, word/bit bookkeeping and shift-register update.
   always_comb begin
      fsm_next_s = state_r;
      k_s        = k_r;
      bit_s      = bit_r;
      sh1_s      = sh1_r;
      sh2_s      = sh2_r;
      case (state_r)
         IDLE: begin
            // busy_r still covers the cycle that carries the done pulse
            if (start_i && !busy_r) begin
               fsm_next_s = FETCH;
               k_s        = IDX_W'(NUM_IO - 1);
            end else begin
               fsm_next_s = IDLE;
            end
         end
         FETCH: begin
            fsm_next_s = SHIFT_LO;
            sh1_s      = cfg_data1_i;
            sh2_s      = cfg_data2_i;
            bit_s      = BIT_W'(CFG_WIDTH - 1);
         end
         SHIFT_LO: begin
            if (tick_s) begin
               fsm_next_s = SHIFT_HI;
            end else begin
               fsm_next_s = SHIFT_LO;
            end
         end
         SHIFT_HI: begin
            if (tick_s) begin
               sh1_s = sh1_r << 1'b1;
               sh2_s = sh2_r << 1'b1;
               if (bit_r != {BIT_W{1'b0}}) begin
                  bit_s      = bit_r - BIT_W'(1);
                  fsm_next_s = SHIFT_LO;
               end else if (k_r != {IDX_W{1'b0}}) begin
                  k_s        = k_r - IDX_W'(1);
                  fsm_next_s = FETCH;
               end else begin
                  fsm_next_s = LOAD;
               end
            end else begin
               fsm_next_s = SHIFT_HI;
            end
         end
         LOAD: begin
            if (tick_s) begin
               fsm_next_s = DONE;
            end else begin
               fsm_next_s = LOAD;
            end
         end
         DONE: begin
            fsm_next_s = IDLE;
         end
         default: begin
            fsm_next_s = IDLE;
         end
      endcase
      state_s = abort_s ? IDLE : fsm_next_s;
   end

   // State and registered outputs, decoded from the state being entered.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_r  <= IDLE;
         k_r      <= {IDX_W{1'b0}};
         bit_r    <= {BIT_W{1'b0}};
         sh1_r    <= {CFG_WIDTH{1'b0}};
         sh2_r    <= {CFG_WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         idx_r    <= {IDX_W{1'b0}};
         clk_r    <= 1'b0;
         load_r   <= 1'b0;
         resetn_r <= 1'b0;
         d1_r     <= 1'b0;
         d2_r     <= 1'b0;
      end else begin
         state_r  <= state_s;
         k_r      <= k_s;
         bit_r    <= bit_s;
         sh1_r    <= sh1_s;
         sh2_r    <= sh2_s;
         busy_r   <= (state_s != IDLE) || ((state_r == DONE) && !abort_s);
         done_r   <= (state_r == DONE) && !abort_s;
         idx_r    <= k_s;
         clk_r    <= (state_s == SHIFT_HI);
         load_r   <= (state_s == LOAD);
         resetn_r <= 1'b1;
         // data moves only when a low phase begins, giving full setup and hold
         if ((state_s == SHIFT_LO) && (state_r != SHIFT_LO)) begin
            d1_r <= sh1_s[CFG_WIDTH-1];
            d2_r <= sh2_s[CFG_WIDTH-1];
         end else begin
            d1_r <= d1_r;
            d2_r <= d2_r;
         end
      end
   end

   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign cfg_idx_o = idx_r;

`ifdef GPIO_CFG_BITBANG_EN
   assign serial_clock_o  = bitbang_en_i ? bb_clock_i  : clk_r;
   assign serial_load_o   = bitbang_en_i ? bb_load_i   : load_r;
   assign serial_resetn_o = bitbang_en_i ? bb_resetn_i : resetn_r;
   assign serial_data1_o  = bitbang_en_i ? bb_data1_i  : d1_r;
   assign serial_data2_o  = bitbang_en_i ? bb_data2_i  : d2_r;
`else
   assign serial_clock_o  = clk_r;
   assign serial_load_o   = load_r;
   assign serial_resetn_o = resetn_r;
   assign serial_data1_o  = d1_r;
   assign serial_data2_o  = d2_r;
`endif

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Directed bench: a 2-word/13-bit/div-2 instance and a 1-word/1-bit/div-1 instance.
// Bypass checks depend on GPIO_CFG_BITBANG_EN.
module tb_gpio_cfg_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks = 0;
   int   fails  = 0;

   // Instance A: NUM_IO=2, CFG_WIDTH=13, CLK_DIV=2
   logic        start_a, busy_a, done_a, sclk_a, sload_a, sres_a, sd1_a, sd2_a;
   logic [0:0]  idx_a;
   logic [12:0] c1_a, c2_a;
   logic        bb_en, bb_clk, bb_load, bb_res, bb_d1, bb_d2;

   // Instance B: NUM_IO=1, CFG_WIDTH=1, CLK_DIV=1
   logic        start_b, busy_b, done_b, sclk_b, sload_b, sres_b, sd1_b, sd2_b;
   logic [0:0]  idx_b;
   logic [0:0]  c1_b, c2_b;
   logic        zero_b;

   assign c1_b   = 1'b1;
   assign c2_b   = 1'b0;
   assign zero_b = 1'b0;

   always_comb begin
      if (idx_a == 1'b1) begin
         c1_a = 13'h1803;
         c2_a = 13'h0403;
      end else begin
         c1_a = 13'h0007;
         c2_a = 13'h1FFF;
      end
   end

   gpio_cfg_serializer #(.NUM_IO(2), .CFG_WIDTH(13), .CLK_DIV(2)) dut (
      .wb_clk_i(clk), .wb_rstn_i(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
      .cfg_idx_o(idx_a), .cfg_data1_i(c1_a), .cfg_data2_i(c2_a),
      .bitbang_en_i(bb_en), .bb_clock_i(bb_clk), .bb_load_i(bb_load), .bb_resetn_i(bb_res),
      .bb_data1_i(bb_d1), .bb_data2_i(bb_d2),
      .serial_clock_o(sclk_a), .serial_load_o(sload_a), .serial_resetn_o(sres_a),
      .serial_data1_o(sd1_a), .serial_data2_o(sd2_a)
   );

   gpio_cfg_serializer #(.NUM_IO(1), .CFG_WIDTH(1), .CLK_DIV(1)) dut_small (
      .wb_clk_i(clk), .wb_rstn_i(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
      .cfg_idx_o(idx_b), .cfg_data1_i(c1_b), .cfg_data2_i(c2_b),
      .bitbang_en_i(zero_b), .bb_clock_i(zero_b), .bb_load_i(zero_b), .bb_resetn_i(zero_b),
      .bb_data1_i(zero_b), .bb_data2_i(zero_b),
      .serial_clock_o(sclk_b), .serial_load_o(sload_b), .serial_resetn_o(sres_b),
      .serial_data1_o(sd1_b), .serial_data2_o(sd2_b)
   );

   // Chain observer for instance A, sampled mid-cycle
   logic        mon_clr = 1'b1;
   int          cyc = 0, rises = 0, loads = 0, load_pulses = 0, dones = 0;
   int          busy_rise_c = 0, busy_fall_c = 0, done_c = 0;
   logic [63:0] cap1 = 64'd0, cap2 = 64'd0;
   logic        prev_clk = 1'b0, prev_busy = 1'b0, prev_load = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mon_clr) begin
         rises = 0; loads = 0; load_pulses = 0; dones = 0;
         busy_rise_c = 0; busy_fall_c = 0; done_c = 0;
         cap1 = 64'd0; cap2 = 64'd0;
      end else begin
         if (sclk_a && !prev_clk) begin
            rises = rises + 1;
            cap1  = {cap1[62:0], sd1_a};
            cap2  = {cap2[62:0], sd2_a};
         end
         if (sload_a) loads = loads + 1;
         if (sload_a && !prev_load) load_pulses = load_pulses + 1;
         if (done_a) begin
            dones  = dones + 1;
            done_c = cyc;
         end
         if (busy_a && !prev_busy) busy_rise_c = cyc;
         if (!busy_a && prev_busy) busy_fall_c = cyc;
      end
      prev_clk  = sclk_a;
      prev_busy = busy_a;
      prev_load = sload_a;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic pulse_start_a();
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a();
      int n = 0;
      while (!(dones > 0 && !busy_a) && n < 300) begin
         tick();
         n = n + 1;
      end
      chk("done_timeout", 64'(n < 300), 64'd1);
      repeat (3) tick();
   endtask

   task automatic check_transfer(input string tag);
      chk({tag, "_rises"}, 64'(rises), 64'd26);
      chk({tag, "_data1"}, cap1, 64'({13'h1803, 13'h0007}));
      chk({tag, "_data2"}, cap2, 64'({13'h0403, 13'h1FFF}));
      chk({tag, "_load_pulses"}, 64'(load_pulses), 64'd1);
      chk({tag, "_load_cycles"}, 64'(loads), 64'd2);
      chk({tag, "_dones"}, 64'(dones), 64'd1);
      chk({tag, "_done_latency"}, 64'(done_c - busy_rise_c), 64'd109);
      chk({tag, "_busy_fall"}, 64'(busy_fall_c - done_c), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
      bb_en = 1'b0; bb_clk = 1'b0; bb_load = 1'b0; bb_res = 1'b0; bb_d1 = 1'b0; bb_d2 = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_a_outputs", 64'({busy_a, done_a, idx_a, sclk_a, sload_a, sres_a, sd1_a, sd2_a}), 64'd0);
      chk("rst_b_outputs", 64'({busy_b, done_b, idx_b, sclk_b, sload_b, sres_b, sd1_b, sd2_b}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("resetn_after_rst_a", 64'(sres_a), 64'd1);
      chk("resetn_after_rst_b", 64'(sres_b), 64'd1);

      // Full transfer with a second start issued mid-transfer
      clr_mon();
      pulse_start_a();
      chk("busy_after_start", 64'(busy_a), 64'd1);
      chk("first_idx", 64'(idx_a), 64'd1);
      repeat (30) tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a();
      check_transfer("xfer1");

      // Reset during the second word
      clr_mon();
      pulse_start_a();
      begin
         int n = 0;
         while (rises < 15 && n < 300) begin
            tick();
            n = n + 1;
         end
         chk("mid_word_timeout", 64'(n < 300), 64'd1);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outputs", 64'({busy_a, done_a, idx_a, sclk_a, sload_a, sres_a, sd1_a, sd2_a}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("midrst_no_load", 64'(load_pulses), 64'd0);
      chk("midrst_no_done", 64'(dones), 64'd0);
      clr_mon();
      pulse_start_a();
      wait_done_a();
      check_transfer("xfer2");

`ifdef GPIO_CFG_BITBANG_EN
      // Bypass mid-transfer: outputs follow bb_*, transfer aborts silently
      clr_mon();
      pulse_start_a();
      repeat (3) tick();
      bb_clk = 1'b1; bb_load = 1'b1; bb_res = 1'b0; bb_d1 = 1'b1; bb_d2 = 1'b1;
      bb_en  = 1'b1;
      #1;
      chk("bb_same_cycle", 64'({sclk_a, sload_a, sres_a, sd1_a, sd2_a}), 64'b11011);
      tick();
      chk("bb_fsm_idle", 64'(busy_a), 64'd0);
      for (int i = 0; i < 13; i++) begin
         bb_clk = ~bb_clk;
         #1;
         chk("bb_clock_mirror", 64'(sclk_a), 64'(i % 2));
         tick();
      end
      pulse_start_a();
      chk("bb_start_ignored", 64'(busy_a), 64'd0);
      repeat (120) tick();
      chk("bb_no_done", 64'(dones), 64'd0);
      bb_en = 1'b0;
      tick();
      chk("bb_release", 64'({sclk_a, sload_a, sres_a, busy_a}), 64'b0010);
`else
      // Bypass disabled at build: bb_* must have no effect
      bb_en = 1'b1; bb_clk = 1'b1; bb_load = 1'b1; bb_res = 1'b0; bb_d1 = 1'b1; bb_d2 = 1'b1;
      clr_mon();
      pulse_start_a();
      chk("nobb_busy", 64'(busy_a), 64'd1);
      wait_done_a();
      check_transfer("nobb");
      bb_en = 1'b0;
`endif

      // Minimal instance: one 1-bit word, single-cycle phases
      tick();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("small_fetch", 64'({busy_b, sclk_b, sload_b, done_b}), 64'b1000);
      tick();
      chk("small_lo", 64'({sclk_b, sd1_b, sd2_b}), 64'b010);
      tick();
      chk("small_hi", 64'({sclk_b, sd1_b, sload_b}), 64'b110);
      tick();
      chk("small_load", 64'({sclk_b, sload_b, done_b}), 64'b010);
      tick();
      chk("small_done_state", 64'({sload_b, done_b, busy_b}), 64'b001);
      tick();
      chk("small_done_pulse", 64'({done_b, busy_b}), 64'b11);
      tick();
      chk("small_idle", 64'({done_b, busy_b}), 64'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
